// File: rtl/obi_pkg.sv
// obi_pkg: shared state type and constants for the OBI crossbar
package obi_pkg;
  typedef enum logic [1:0] {IDLE, LOCK, RESP} sub_state_e;
  localparam int SEL_LSB_DEF = 20;
  localparam int SEL_W_DEF = 2;
  localparam int DRAM = 0;
  localparam int IRAM = 1;
  localparam int WB = 3;
  localparam logic [7:0] DEC_ERR_BYTE = 8'h00;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or above the pointer, pointer moves past the granted index on upd
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          upd,
  input  logic [IW-1:0] upd_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (gnt == '0 && req[j]) begin
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) ptr <= '0;
    else if (upd) ptr <= (int'(upd_idx) == N - 1) ? '0 : upd_idx + 1'b1;
endmodule

// File: rtl/obi_xbar.sv
// obi_xbar: NUM_M x NUM_S OBI crossbar with per-subordinate round-robin and decode-error responses
module obi_xbar
  import obi_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int NUM_S = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_LSB = SEL_LSB_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_M-1:0]          m_req_i,
  output logic [NUM_M-1:0]          m_gnt_o,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M*DATA_W/8-1:0] m_be_i,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata_i,
  output logic [NUM_M-1:0]          m_rvalid_o,
  output logic [NUM_M*DATA_W-1:0]   m_rdata_o,
  output logic [NUM_M-1:0]          m_err_o,
  output logic [NUM_S-1:0]          s_req_o,
  input  logic [NUM_S-1:0]          s_gnt_i,
  output logic [NUM_S*ADDR_W-1:0]   s_addr_o,
  output logic [NUM_S-1:0]          s_we_o,
  output logic [NUM_S*DATA_W/8-1:0] s_be_o,
  output logic [NUM_S*DATA_W-1:0]   s_wdata_o,
  input  logic [NUM_S-1:0]          s_rvalid_i,
  input  logic [NUM_S*DATA_W-1:0]   s_rdata_i
);
  localparam int BE_W = DATA_W / 8;
  localparam int MW = NUM_M > 1 ? $clog2(NUM_M) : 1;
  logic [SEL_W-1:0] tgt [NUM_M];
  logic [NUM_M-1:0] mapped, elig, pend_q, err_q, set_pend, clr_pend;
  logic [NUM_M-1:0] arb_req [NUM_S];
  logic [NUM_M-1:0] arb_gnt [NUM_S];
  logic [MW-1:0] arb_idx [NUM_S];
  logic [MW-1:0] sel [NUM_S];
  logic [MW-1:0] own_q [NUM_S];
  logic [MW-1:0] own_d [NUM_S];
  logic [NUM_S-1:0] arb_upd;
  sub_state_e st_q [NUM_S];
  sub_state_e st_d [NUM_S];
  always_comb begin
    tgt = '{default: '0};
    mapped = '0;
    elig = '0;
    arb_req = '{default: '0};
    for (int m = 0; m < NUM_M; m++) begin
      tgt[m] = m_addr_i[m*ADDR_W+SEL_LSB +: SEL_W];
      mapped[m] = {1'b0, tgt[m]} < (SEL_W+1)'(NUM_S);
      elig[m] = m_req_i[m] & ~pend_q[m];
    end
    for (int s = 0; s < NUM_S; s++)
      for (int m = 0; m < NUM_M; m++)
        arb_req[s][m] = elig[m] & mapped[m] & (tgt[m] == SEL_W'(s));
  end
  for (genvar i = 0; i < NUM_S; i++) begin : g_arb
    rr_arbiter #(.N(NUM_M)) u_arb (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req(arb_req[i]),
      .upd(arb_upd[i]),
      .upd_idx(sel[i]),
      .gnt(arb_gnt[i]),
      .idx(arb_idx[i])
    );
  end
  always_comb begin
    m_gnt_o = '0;
    m_rvalid_o = '0;
    m_err_o = '0;
    m_rdata_o = '0;
    s_req_o = '0;
    s_addr_o = '0;
    s_we_o = '0;
    s_be_o = '0;
    s_wdata_o = '0;
    set_pend = '0;
    clr_pend = '0;
    arb_upd = '0;
    st_d = st_q;
    own_d = own_q;
    sel = own_q;
    if (!rst_i) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (elig[m] && !mapped[m]) begin
          m_gnt_o[m] = 1'b1;
          set_pend[m] = 1'b1;
        end
        if (err_q[m]) begin
          m_rvalid_o[m] = 1'b1;
          m_err_o[m] = 1'b1;
          m_rdata_o[m*DATA_W +: DATA_W] = {BE_W{DEC_ERR_BYTE}};
          clr_pend[m] = 1'b1;
        end
      end
      for (int s = 0; s < NUM_S; s++) begin
        sel[s] = st_q[s] == IDLE ? arb_idx[s] : own_q[s];
        s_req_o[s] = st_q[s] == IDLE ? |arb_gnt[s] : st_q[s] == LOCK && m_req_i[sel[s]];
        s_addr_o[s*ADDR_W +: ADDR_W] = m_addr_i[int'(sel[s])*ADDR_W +: ADDR_W];
        s_we_o[s] = m_we_i[sel[s]];
        s_be_o[s*BE_W +: BE_W] = m_be_i[int'(sel[s])*BE_W +: BE_W];
        s_wdata_o[s*DATA_W +: DATA_W] = m_wdata_i[int'(sel[s])*DATA_W +: DATA_W];
        if (s_req_o[s]) begin
          own_d[s] = sel[s];
          st_d[s] = s_gnt_i[s] ? RESP : LOCK;
          if (s_gnt_i[s]) begin
            m_gnt_o[sel[s]] = 1'b1;
            set_pend[sel[s]] = 1'b1;
            arb_upd[s] = 1'b1;
          end
        end else if (st_q[s] == LOCK) st_d[s] = IDLE;
        if (st_q[s] == RESP && s_rvalid_i[s]) begin
          m_rvalid_o[own_q[s]] = 1'b1;
          m_rdata_o[int'(own_q[s])*DATA_W +: DATA_W] = s_rdata_i[s*DATA_W +: DATA_W];
          clr_pend[own_q[s]] = 1'b1;
          st_d[s] = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pend_q <= '0;
      err_q <= '0;
      st_q <= '{default: IDLE};
      own_q <= '{default: '0};
    end else begin
      pend_q <= (pend_q | set_pend) & ~clr_pend;
      err_q <= elig & ~mapped;
      st_q <= st_d;
      own_q <= own_d;
    end
endmodule
